mppt_po_ctrl: RTL
=================

MPPT_PO_CTRL -- requirements
Module: mppt_po_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 10, meaning duty-cycle word width.
REQ-002 The block SHALL have parameter STEP, default 4, meaning duty perturbation per iteration.
REQ-003 The block SHALL have parameters DUTY_MIN, DUTY_MAX and DUTY_INIT, defaults 64, 960 and 512, meaning the clamp limits and the reset duty.
REQ-004 The block SHALL have parameter SETTLE, default 200, range 1..255, meaning converter settling time in clk cycles after each duty change.
REQ-005 Ports SHALL be:
  clk  in  1  single clock, rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  start  in  1  run enable (level).
  adc_req  out  1  conversion request.
  adc_ack  in  1  one-cycle pulse; adc_v and adc_i are valid in that cycle.
  adc_v  in  12  panel voltage sample.
  adc_i  in  12  panel current sample.
  duty  out  DW  PWM duty command (registered).
  dir  out  1  perturbation direction (1 = increase).
  busy  out  1  high in any state except IDLE.
  step_done  out  1  one-cycle pulse per completed iteration.

Function
REQ-006 The FSM SHALL have states IDLE, SETTLE, SAMPLE, CALC, COMPARE and UPDATE, encoded in a 3-bit state register.
REQ-007 IDLE SHALL move to SETTLE when start=1, and SHALL otherwise hold with duty unchanged.
REQ-008 A down-counter SHALL be loaded with SETTLE-1 on entry to SETTLE; SETTLE SHALL occupy exactly SETTLE cycles and then move to SAMPLE.
REQ-009 adc_req SHALL be 1 in every SAMPLE cycle, from the first SAMPLE cycle through the cycle in which adc_ack=1.
REQ-010 In the adc_ack=1 cycle, v and i SHALL be registered and the FSM SHALL move to CALC; adc_req SHALL be 0 in the following cycle.
REQ-011 adc_ack SHALL be ignored outside SAMPLE.
REQ-012 CALC SHALL take 1 cycle and register p_new = v*i as 24-bit unsigned, full precision, with no truncation.
REQ-013 COMPARE SHALL take 1 cycle: if p_new < p_prev, dir SHALL toggle; if p_new >= p_prev, dir SHALL hold (equal power keeps direction).
REQ-014 UPDATE SHALL take 1 cycle and apply the following:
  - dir=1 and duty+STEP >= DUTY_MAX: duty <= DUTY_MAX, dir <= 0.
  - dir=1 otherwise: duty <= duty+STEP.
  - dir=0 and duty <= DUTY_MIN+STEP: duty <= DUTY_MIN, dir <= 1.
  - dir=0 otherwise: duty <= duty-STEP.
REQ-015 Duty arithmetic SHALL be performed at DW+1 bits so that no wrap-around can occur.
REQ-016 In UPDATE, p_prev SHALL be loaded with p_new and step_done SHALL be 1 for exactly that cycle.
REQ-017 UPDATE SHALL move to SETTLE if start=1, and to IDLE if start=0.
REQ-018 start falling mid-iteration SHALL NOT abort the iteration; the iteration SHALL complete through UPDATE.
REQ-019 The first iteration after reset SHALL compare against p_prev=0, so dir SHALL hold on that iteration.
REQ-020 One iteration SHALL last SETTLE + (SAMPLE cycles) + 3 cycles.

Reset
REQ-021 When rst_n=0 at a rising clk edge, the block SHALL set state=IDLE, duty=DUTY_INIT, dir=1, p_prev=0, v=0, i=0, counter=0, adc_req=0, busy=0 and step_done=0.
REQ-022 Reset SHALL take priority over all other inputs in every state, including mid-SAMPLE with adc_req=1.
REQ-023 adc_req SHALL be 0 in the first cycle after reset is released.

Verification
REQ-024 With SETTLE=4, start=1, and adc_ack given 2 cycles after adc_req rises with v=100 and i=50: the bench SHALL check p_new=5000, dir=1, duty 512->516, step_done 4+3+3 cycles after start.
REQ-025 With a second iteration at v=100, i=40 (p_new=4000 < 5000): the bench SHALL check dir->0 and duty 516->512; with a third iteration at equal power: dir SHALL stay 0 and duty SHALL go to 508.
REQ-026 With duty=958, dir=1 and increasing power: the bench SHALL check duty=960 and dir=0 after UPDATE; from duty=66, dir=0: the bench SHALL check duty=64 and dir=1.
REQ-027 With start deasserted during SETTLE: the bench SHALL check that the iteration completes, step_done pulses once, the FSM reaches IDLE, busy=0 and duty holds.
REQ-028 With rst_n=0 for 1 cycle while in SAMPLE with adc_req=1: the bench SHALL check adc_req=0, duty=512, dir=1 and state=IDLE on the next cycle, and that a late adc_ack is ignored.
REQ-029 With adc_ack pulsed in IDLE or SETTLE: the bench SHALL check that v, i and the state are unchanged.

Source files
------------

// File: rtl/mppt_po_ctrl.sv
// Perturb-and-observe MPPT controller: steps the PWM duty, measures panel
// power after the converter settles, and reverses direction when power drops.
module mppt_po_ctrl #(
  parameter int unsigned DW        = 10,
  parameter int unsigned STEP      = 4,
  parameter int unsigned DUTY_MIN  = 64,
  parameter int unsigned DUTY_MAX  = 960,
  parameter int unsigned DUTY_INIT = 512,
  parameter int unsigned SETTLE    = 200
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          adc_req,
  input  logic          adc_ack,
  input  logic [11:0]   adc_v,
  input  logic [11:0]   adc_i,
  output logic [DW-1:0] duty,
  output logic          dir,
  output logic          busy,
  output logic          step_done
);

  localparam int unsigned AW = 12;
  localparam int unsigned PW = 24;
  localparam int unsigned CW = 8;
  localparam int unsigned EW = DW + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SAMPLE  = 3'd2,
    ST_CALC    = 3'd3,
    ST_COMPARE = 3'd4,
    ST_UPDATE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] v_q, i_q;
  logic [PW-1:0] p_new_q, p_prev_q;
  logic [EW-1:0] duty_inc;
  logic [DW-1:0] duty_upd;
  logic          dir_upd;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an iteration always runs through UPDATE once begun
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_SETTLE;
      ST_SETTLE:  if (cnt_q == '0) state_d = ST_SAMPLE;
      ST_SAMPLE:  if (adc_ack) state_d = ST_CALC;
      ST_CALC:    state_d = ST_COMPARE;
      ST_COMPARE: state_d = ST_UPDATE;
      ST_UPDATE:  state_d = start ? ST_SETTLE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Duty perturbation with clamping, evaluated one bit wider than the duty word
  always_comb begin
    duty_inc = EW'(duty) + EW'(STEP);
    duty_upd = duty;
    dir_upd  = dir;
    if (dir) begin
      if (duty_inc >= EW'(DUTY_MAX)) begin
        duty_upd = DW'(DUTY_MAX);
        dir_upd  = 1'b0;
      end else begin
        duty_upd = DW'(duty_inc);
      end
    end else begin
      if (EW'(duty) <= EW'(DUTY_MIN) + EW'(STEP)) begin
        duty_upd = DW'(DUTY_MIN);
        dir_upd  = 1'b1;
      end else begin
        duty_upd = DW'(EW'(duty) - EW'(STEP));
      end
    end
  end

  // Settling down-counter, loaded on every entry into SETTLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d == ST_SETTLE && state_q != ST_SETTLE) begin
      cnt_q <= CW'(SETTLE - 1);
    end else if (state_q == ST_SETTLE && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Sample capture, power computation, direction and duty update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q      <= '0;
      i_q      <= '0;
      p_new_q  <= '0;
      p_prev_q <= '0;
      duty     <= DW'(DUTY_INIT);
      dir      <= 1'b1;
    end else begin
      if (state_q == ST_SAMPLE && adc_ack) begin
        v_q <= adc_v;
        i_q <= adc_i;
      end
      if (state_q == ST_CALC) p_new_q <= PW'(v_q) * PW'(i_q);
      if (state_q == ST_COMPARE && p_new_q < p_prev_q) dir <= ~dir;
      if (state_q == ST_UPDATE) begin
        duty     <= duty_upd;
        dir      <= dir_upd;
        p_prev_q <= p_new_q;
      end
    end
  end

  // Status outputs registered from the next state so they align with the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adc_req   <= 1'b0;
      busy      <= 1'b0;
      step_done <= 1'b0;
    end else begin
      adc_req   <= (state_d == ST_SAMPLE);
      busy      <= (state_d != ST_IDLE);
      step_done <= (state_d == ST_UPDATE);
    end
  end

endmodule
